// File: rtl/alu_op_sequencer_if.sv
// Handshake bundle between the instruction decoder and the ALU sequencer.
// The operation request channel and the held-result channel share one bundle.
// The requester uses the master view. The sequencer uses the slave view.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             op_valid;
  logic             op_ready;
  logic [3:0]       op_code;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_flag;
  logic             res_err;

  modport master (
    output op_valid, op_code, op_a, op_b, res_ready,
    input  op_ready, res_valid, res_data, res_flag, res_err
  );

  modport slave (
    input  op_valid, op_code, op_a, op_b, res_ready,
    output op_ready, res_valid, res_data, res_flag, res_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Front-end controller for the 4-bit ArithmeticLogicUnit.
// It takes one operation at a time, decodes the opcode into a single one-hot
// ALU strobe, and preloads the ALU shift register before a shift. It then
// holds the result, flag and error bit until the consumer takes them.
module alu_op_sequencer #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_op_sequencer_if.slave    bus,
  output logic [WIDTH-1:0]     alu_in1,
  output logic [WIDTH-1:0]     alu_in2,
  output logic                 alu_add,
  output logic                 alu_sub,
  output logic                 alu_lsr,
  output logic                 alu_lsh,
  output logic                 alu_rsh,
  output logic                 alu_and,
  output logic                 alu_or,
  output logic                 alu_xor,
  output logic                 alu_inv,
  output logic                 alu_clr,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic                 alu_overflow,
  input  logic                 alu_shift_flag,
  output logic [CNT_WIDTH-1:0] op_count
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_LSH = 4'd2;
  localparam logic [3:0] OP_RSH = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_INV = 4'd7;
  localparam logic [3:0] OP_CLR = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [3:0]           r_code;
  logic [WIDTH-1:0]     r_in1;
  logic [WIDTH-1:0]     r_in2;
  logic [WIDTH-1:0]     r_resData;
  logic                 r_resFlag;
  logic                 r_resErr;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 w_opReady;
  logic                 w_resValid;
  logic                 w_isShift;
  logic                 w_isLegal;

  assign w_isShift = (bus.op_code == OP_LSH) || (bus.op_code == OP_RSH);
  assign w_isLegal = (bus.op_code <= OP_CLR);

  // State register; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode plus the handshake and one-hot strobe outputs
  always_comb begin
    w_nextState = r_state;
    w_opReady   = 1'b0;
    w_resValid  = 1'b0;
    alu_add     = 1'b0;
    alu_sub     = 1'b0;
    alu_lsr     = 1'b0;
    alu_lsh     = 1'b0;
    alu_rsh     = 1'b0;
    alu_and     = 1'b0;
    alu_or      = 1'b0;
    alu_xor     = 1'b0;
    alu_inv     = 1'b0;
    alu_clr     = 1'b0;
    case (r_state)
      IDLE: begin
        w_opReady = 1'b1;
        if (bus.op_valid) begin
          if (!w_isLegal) begin
            w_nextState = HOLD;
          end else if (w_isShift) begin
            w_nextState = LOAD;
          end else begin
            w_nextState = EXEC;
          end
        end
      end
      LOAD: begin
        alu_lsr     = 1'b1;
        w_nextState = EXEC;
      end
      EXEC: begin
        case (r_code)
          OP_ADD:  alu_add = 1'b1;
          OP_SUB:  alu_sub = 1'b1;
          OP_LSH:  alu_lsh = 1'b1;
          OP_RSH:  alu_rsh = 1'b1;
          OP_AND:  alu_and = 1'b1;
          OP_OR:   alu_or  = 1'b1;
          OP_XOR:  alu_xor = 1'b1;
          OP_INV:  alu_inv = 1'b1;
          OP_CLR:  alu_clr = 1'b1;
          default: ;
        endcase
        w_nextState = HOLD;
      end
      HOLD: begin
        w_resValid = 1'b1;
        if (bus.res_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Operand latch, result/flag capture and completed-operation counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_code    <= '0;
      r_in1     <= '0;
      r_in2     <= '0;
      r_resData <= '0;
      r_resFlag <= 1'b0;
      r_resErr  <= 1'b0;
      r_count   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.op_valid) begin
            r_code <= bus.op_code;
            if (w_isLegal) begin
              r_in1 <= bus.op_a;
              r_in2 <= bus.op_b;
            end else begin
              r_resData <= '0;
              r_resFlag <= 1'b0;
              r_resErr  <= 1'b1;
            end
          end
        end
        EXEC: begin
          r_resData <= alu_out;
          r_resErr  <= 1'b0;
          case (r_code)
            OP_ADD, OP_SUB: r_resFlag <= alu_overflow;
            OP_LSH, OP_RSH: r_resFlag <= alu_shift_flag;
            default:        r_resFlag <= 1'b0;
          endcase
        end
        HOLD: begin
          if (bus.res_ready) begin
            r_count <= r_count + CNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_in1       = r_in1;
  assign alu_in2       = r_in2;
  assign op_count      = r_count;
  assign bus.op_ready  = w_opReady;
  assign bus.res_valid = w_resValid;
  assign bus.res_data  = r_resData;
  assign bus.res_flag  = r_resFlag;
  assign bus.res_err   = r_resErr;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a small behavioural ALU.
// Expected results are queued when an operation is driven. They are popped
// and compared when the sequencer presents the held result.
module tb_alu_op_sequencer;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;
  localparam logic [9:0] LSR_BIT = 10'b00_1000_0000;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             flag;
    logic             err;
    int               lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] alu_in1, alu_in2, alu_out;
  logic             alu_add, alu_sub, alu_lsr, alu_lsh, alu_rsh;
  logic             alu_and, alu_or, alu_xor, alu_inv, alu_clr;
  logic             alu_overflow, alu_shift_flag;
  logic [CNT_W-1:0] op_count;
  logic [9:0]       strobes;
  logic [WIDTH-1:0] shReg = '0;
  logic [CNT_W-1:0] modelCount;
  exp_t             sb[$];
  int               vectors = 0;
  int               miscompares = 0;

  alu_op_sequencer_if #(.WIDTH(WIDTH)) bus();

  alu_op_sequencer #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_add(alu_add), .alu_sub(alu_sub), .alu_lsr(alu_lsr),
    .alu_lsh(alu_lsh), .alu_rsh(alu_rsh), .alu_and(alu_and),
    .alu_or(alu_or), .alu_xor(alu_xor), .alu_inv(alu_inv),
    .alu_clr(alu_clr), .alu_out(alu_out), .alu_overflow(alu_overflow),
    .alu_shift_flag(alu_shift_flag), .op_count(op_count)
  );

  always #5 clk = ~clk;

  assign strobes = {alu_add, alu_sub, alu_lsr, alu_lsh, alu_rsh,
                    alu_and, alu_or, alu_xor, alu_inv, alu_clr};

  // ALU shift register loads in1 whenever the load strobe is seen on an edge
  always @(posedge clk) begin
    if (alu_lsr) shReg <= alu_in1;
  end

  // Combinational ALU; flags carry junk when unused so a wrong flag pick shows
  always_comb begin
    logic [WIDTH:0] sum;
    sum            = {1'b0, alu_in1} + {1'b0, alu_in2};
    alu_out        = '0;
    alu_overflow   = sum[WIDTH];
    alu_shift_flag = shReg[WIDTH-1];
    if (alu_add) begin
      alu_out = sum[WIDTH-1:0];
    end else if (alu_sub) begin
      sum          = {1'b0, alu_in1} - {1'b0, alu_in2};
      alu_out      = sum[WIDTH-1:0];
      alu_overflow = sum[WIDTH];
    end else if (alu_lsh) begin
      alu_out = shReg << 1;
    end else if (alu_rsh) begin
      alu_out        = shReg >> 1;
      alu_shift_flag = shReg[0];
    end else if (alu_and) begin
      alu_out = alu_in1 & alu_in2;
    end else if (alu_or) begin
      alu_out = alu_in1 | alu_in2;
    end else if (alu_xor) begin
      alu_out = alu_in1 ^ alu_in2;
    end else if (alu_inv) begin
      alu_out = ~alu_in1;
    end
  end

  function automatic logic [9:0] strobeFor(input logic [3:0] code);
    case (code)
      4'd0:    return 10'b10_0000_0000;
      4'd1:    return 10'b01_0000_0000;
      4'd2:    return 10'b00_0100_0000;
      4'd3:    return 10'b00_0010_0000;
      4'd4:    return 10'b00_0001_0000;
      4'd5:    return 10'b00_0000_1000;
      4'd6:    return 10'b00_0000_0100;
      4'd7:    return 10'b00_0000_0010;
      4'd8:    return 10'b00_0000_0001;
      default: return 10'b00_0000_0000;
    endcase
  endfunction

  function automatic exp_t model(input logic [3:0] code, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    logic [4:0] wide;
    e.data = '0; e.flag = 1'b0; e.err = 1'b0; e.lat = 2;
    case (code)
      4'd0: begin wide = {1'b0, a} + {1'b0, b}; e.data = wide[3:0]; e.flag = wide[4]; end
      4'd1: begin wide = {1'b0, a} - {1'b0, b}; e.data = wide[3:0]; e.flag = wide[4]; end
      4'd2: begin e.data = {a[2:0], 1'b0}; e.flag = a[3]; e.lat = 3; end
      4'd3: begin e.data = {1'b0, a[3:1]}; e.flag = a[0]; e.lat = 3; end
      4'd4: e.data = a & b;
      4'd5: e.data = a | b;
      4'd6: e.data = a ^ b;
      4'd7: e.data = ~a;
      4'd8: e.data = '0;
      default: begin e.err = 1'b1; e.lat = 1; end
    endcase
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one operation, follow it cycle by cycle, optionally stall the result
  task automatic applyStimulus(input logic [3:0] code, input logic [3:0] a,
                               input logic [3:0] b, input int holdCycles);
    exp_t e, got;
    int waitCnt, lat;
    logic [9:0] expS;
    bit done;
    e = model(code, a, b);
    @(negedge clk);
    bus.res_ready = (holdCycles == 0);
    bus.op_valid  = 1'b1;
    bus.op_code   = code;
    bus.op_a      = a;
    bus.op_b      = b;
    waitCnt = 0;
    while (!bus.op_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!bus.op_ready) begin
      checkOutput("op_ready timeout", 32'(bus.op_ready), 32'(1));
      bus.op_valid  = 1'b0;
      bus.res_ready = 1'b1;
      return;
    end
    sb.push_back(e);
    @(posedge clk);
    #1 bus.op_valid = 1'b0;
    lat  = 0;
    done = 1'b0;
    for (int cyc = 1; cyc <= 10 && !done; cyc++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        lat  = cyc;
        done = 1'b1;
        checkOutput("strobes in HOLD", 32'(strobes), 32'(0));
      end else begin
        expS = (e.lat == 3 && cyc == 1) ? LSR_BIT : strobeFor(code);
        checkOutput("strobe pattern", 32'(strobes), 32'(expS));
        checkOutput("alu_in1", 32'(alu_in1), 32'(a));
        if (expS != LSR_BIT) checkOutput("alu_in2", 32'(alu_in2), 32'(b));
      end
    end
    checkOutput("latency", 32'(lat), 32'(e.lat));
    if (!done) begin
      void'(sb.pop_front());
      bus.res_ready = 1'b1;
      return;
    end
    for (int h = 0; h < holdCycles; h++) begin
      checkOutput("hold res_valid", 32'(bus.res_valid), 32'(1));
      checkOutput("hold res_data", 32'(bus.res_data), 32'(e.data));
      checkOutput("hold op_ready", 32'(bus.op_ready), 32'(0));
      checkOutput("hold op_count", 32'(op_count), 32'(modelCount));
      bus.op_valid = 1'b1;
      bus.op_code  = 4'd0;
      bus.op_a     = 4'hF;
      bus.op_b     = 4'hF;
      @(negedge clk);
    end
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b1;
    got = sb.pop_front();
    checkOutput("res_valid", 32'(bus.res_valid), 32'(1));
    checkOutput("res_data", 32'(bus.res_data), 32'(got.data));
    checkOutput("res_flag", 32'(bus.res_flag), 32'(got.flag));
    checkOutput("res_err", 32'(bus.res_err), 32'(got.err));
    @(posedge clk);
    modelCount++;
    #1;
    checkOutput("op_count", 32'(op_count), 32'(modelCount));
    checkOutput("op_ready after handoff", 32'(bus.op_ready), 32'(1));
  endtask

  // Guard against a stuck run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence
  initial begin
    int waitCnt;
    bus.op_valid  = 1'b0;
    bus.op_code   = 4'd0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.res_ready = 1'b1;
    reset         = 1'b1;
    modelCount    = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset op_ready", 32'(bus.op_ready), 32'(1));
    checkOutput("reset res_valid", 32'(bus.res_valid), 32'(0));
    checkOutput("reset strobes", 32'(strobes), 32'(0));
    checkOutput("reset op_count", 32'(op_count), 32'(0));
    checkOutput("reset res_data", 32'(bus.res_data), 32'(0));
    checkOutput("reset res_err", 32'(bus.res_err), 32'(0));
    checkOutput("reset alu_in1", 32'(alu_in1), 32'(0));
    checkOutput("reset alu_in2", 32'(alu_in2), 32'(0));

    applyStimulus(4'd0, 4'd9, 4'd8, 0);
    applyStimulus(4'd1, 4'd3, 4'd5, 0);
    applyStimulus(4'd2, 4'b1001, 4'd0, 0);
    applyStimulus(4'd3, 4'b1001, 4'd0, 0);
    applyStimulus(4'hB, 4'd7, 4'd7, 0);
    applyStimulus(4'd4, 4'hC, 4'hA, 0);
    applyStimulus(4'd6, 4'h6, 4'h3, 4);

    // Reset while the shift preload is in progress
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = 4'd2;
    bus.op_a     = 4'b1001;
    bus.op_b     = 4'd0;
    waitCnt = 0;
    while (!bus.op_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("op_ready before reset test", 32'(bus.op_ready), 32'(1));
    @(posedge clk);
    #1 bus.op_valid = 1'b0;
    @(negedge clk);
    checkOutput("lsr in LOAD", 32'(strobes), 32'(LSR_BIT));
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid-op reset op_ready", 32'(bus.op_ready), 32'(1));
    checkOutput("mid-op reset strobes", 32'(strobes), 32'(0));
    checkOutput("mid-op reset res_valid", 32'(bus.res_valid), 32'(0));
    checkOutput("mid-op reset op_count", 32'(op_count), 32'(0));
    checkOutput("mid-op reset alu_in1", 32'(alu_in1), 32'(0));
    reset      = 1'b0;
    modelCount = '0;

    applyStimulus(4'd5, 4'h5, 4'hA, 0);
    applyStimulus(4'd7, 4'h6, 4'h0, 0);
    applyStimulus(4'd8, 4'hF, 4'hF, 0);
    applyStimulus(4'd0, 4'h7, 4'h7, 0);
    checkOutput("op_count wrap", 32'(op_count), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Front-end controller for the 4-bit ArithmeticLogicUnit.
- Accepts one operation at a time over a valid/ready handshake and decodes the 4-bit opcode into the ALU's one-hot strobes (ADD, SUB, LSR, LSH, RSH, AND, OR, XOR, INV, CLR).
- Sequences the two-step shift (load, then shift) and captures the result plus flag into a held output with its own valid/ready handshake.
- Sits between the instruction decoder and the ALU instance.

Parameters:
- WIDTH, 4, operand/result width; must match the ALU datapath.
- CNT_WIDTH, 8, width of the completed-operation counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  operation request.
- op_ready  out  1  sequencer can accept an operation.
- op_code  in  4  0 ADD, 1 SUB, 2 LSH, 3 RSH, 4 AND, 5 OR, 6 XOR, 7 INV, 8 CLR, 9-15 illegal.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- alu_in1  out  WIDTH  to ALU in1.
- alu_in2  out  WIDTH  to ALU in2.
- alu_add, alu_sub, alu_lsr, alu_lsh, alu_rsh, alu_and, alu_or, alu_xor, alu_inv, alu_clr  out  1 each  ALU strobes.
- alu_out  in  WIDTH  ALU result.
- alu_overflow  in  1  ALU overflow.
- alu_shift_flag  in  1  ALU shiftFlag.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  WIDTH  captured result.
- res_flag  out  1  captured flag.
- res_err  out  1  illegal opcode.
- op_count  out  CNT_WIDTH  completed operations; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (synchronous, active-high; also applies mid-operation):
  - State goes to IDLE.
  - All strobes, res_valid, res_data, res_flag, res_err, op_count, alu_in1 and alu_in2 are cleared to 0.
  - op_ready is 1 in the first cycle after reset deasserts.
- FSM states: IDLE, LOAD, EXEC, HOLD.
- IDLE:
  - op_ready = 1.
  - On op_valid & op_ready, register op_code, op_a and op_b.
  - Next state is LOAD for opcodes 2/3, HOLD for illegal opcodes, otherwise EXEC.
- LOAD (shift only, one cycle):
  - alu_lsr = 1 and alu_in1 = op_a, so the ALU shift register captures op_a at the end of this cycle.
  - Next state is EXEC.
- EXEC (one cycle):
  - Exactly one strobe is asserted for the latched opcode.
  - alu_in1 = op_a and alu_in2 = op_b.
  - At the end of the cycle, capture res_data = alu_out.
  - res_flag = alu_overflow for ADD/SUB, alu_shift_flag for LSH/RSH, 0 otherwise.
  - res_err = 0.
  - Next state is HOLD.
- Illegal opcode: no strobe is ever asserted; entering HOLD loads res_data = 0, res_flag = 0, res_err = 1.
- HOLD:
  - res_valid = 1.
  - res_data, res_flag and res_err are stable until res_ready.
  - On res_ready, op_count increments (illegal opcodes included) and next state is IDLE.
  - op_ready = 0; no accept in the same cycle as result handoff.
- Strobes:
  - Driven only in LOAD/EXEC; zero in IDLE and HOLD.
  - Never more than one strobe is high in any cycle.
  - alu_lsr is high only in LOAD.
- alu_in1 and alu_in2 hold their last values outside LOAD/EXEC.
- Latency from the accept edge to res_valid high:
  - 2 cycles for non-shift operations.
  - 3 cycles for shifts.
  - 1 cycle for illegal opcodes.
- Peak throughput is one operation per 3 cycles (non-shift, res_ready held high).
- Backpressure: with res_ready low, the sequencer stays in HOLD indefinitely.
- op_valid is ignored outside IDLE; the requester must hold it until op_ready is sampled.
- op_count wraps from 2^CNT_WIDTH-1 to 0 with no flag.

Test Plan:
- ADD, op_a = 9, op_b = 8, res_ready = 1 -> alu_add high for exactly one cycle (cycle 1); res_valid at cycle 2 with res_data = 1, res_flag = 1; op_count = 1.
- SUB, op_a = 3, op_b = 5 -> res_data = 0xE, res_flag = 1; only alu_sub ever high.
- LSH, op_a = 4'b1001 -> alu_lsr high in cycle 1 only; alu_lsh high in cycle 2 only; res_valid at cycle 3 with res_data = 4'b0010, res_flag = 1. Repeat with RSH on 4'b1001 -> res_data = 4'b0100.
- op_code = 0xB -> no strobe in any cycle; res_valid at cycle 1 with res_data = 0, res_flag = 0, res_err = 1; a following AND 0xC, 0xA -> res_data = 0x8, res_err = 0.
- XOR 0x6, 0x3 with res_ready low for 4 cycles -> res_valid held, res_data = 0x5 stable, op_ready = 0, new op_valid ignored; op_count increments once on the handshake.
- Reset asserted during LOAD of an LSH -> next cycle: state IDLE, all strobes 0, res_valid 0, op_count 0. With CNT_WIDTH = 2, four completed ops -> op_count = 0.
